calc_display_driver: RTL and testbench

- Downstream consumer of the calculator controller's 16-bit signed result (display_output) and its complete pulse.
- Converts the two's-complement result to sign plus 5 BCD digits using an iterative double-dabble.
- Drives a 6-digit multiplexed common-cathode seven-segment display.
- Decouples the arithmetic path from display timing: the controller loads a result, and the driver converts and then refreshes continuously.

---
 rtl/calc_display_driver.sv | 165 ++++++++++++++++
 tb/tb_calc_display_driver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/calc_display_driver.sv
// Converts a signed 16-bit result to sign + 5 BCD digits (iterative double-dabble)
// and scans them onto a 6-digit common-cathode display. Define DISP_LZB_EN for leading-zero blanking.
module calc_display_driver #(
    parameter int SCAN_DIV   = 1000,
    parameter int NUM_DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [15:0]           value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    typedef enum logic [1:0] {IDLE, ABS, CONV, LATCH} state_t;

    state_t      state_q, state_d;
    logic [15:0] val_q, val_d;
    logic        sign_q, sign_d;
    logic [15:0] mag_q, mag_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [19:0] dig_q, dig_d;
    logic        dsign_q, dsign_d;
    logic [15:0] pre_q, pre_d;
    logic [2:0]  idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    function automatic logic [19:0] dd_adj(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++)
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0: dec7 = 7'h3F;
            4'd1: dec7 = 7'h06;
            4'd2: dec7 = 7'h5B;
            4'd3: dec7 = 7'h4F;
            4'd4: dec7 = 7'h66;
            4'd5: dec7 = 7'h6D;
            4'd6: dec7 = 7'h7D;
            4'd7: dec7 = 7'h07;
            4'd8: dec7 = 7'h7F;
            4'd9: dec7 = 7'h6F;
            default: dec7 = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input logic [2:0] idx, input logic [19:0] d, input logic s);
        logic [3:0] n;
        logic       blank;
        blank = 1'b0;
        case (idx)
            3'd0: n = d[3:0];
            3'd1: n = d[7:4];
            3'd2: n = d[11:8];
            3'd3: n = d[15:12];
            3'd4: n = d[19:16];
            default: n = 4'hF;
        endcase
`ifdef DISP_LZB_EN
        // A digit is blank when it and every digit above it are zero; digit 0 never blanks.
        case (idx)
            3'd1: blank = (d[19:4]  == 16'd0);
            3'd2: blank = (d[19:8]  == 12'd0);
            3'd3: blank = (d[19:12] == 8'd0);
            3'd4: blank = (d[19:16] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
        if (idx == 3'd5)  return s ? 7'h40 : 7'h00;
        else if (blank)   return 7'h00;
        else              return dec7(n);
    endfunction

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        dsign_d = dsign_q;
        case (state_q)
            IDLE: if (load) begin
                val_d   = value_in;
                state_d = ABS;
            end
            ABS: begin
                sign_d  = val_q[15];
                mag_d   = val_q[15] ? (~val_q + 16'd1) : val_q;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                {bcd_d, mag_d} = {dd_adj(bcd_q), mag_q} << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) state_d = LATCH;
            end
            LATCH: begin
                dig_d   = bcd_q;
                dsign_d = sign_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // an/seg are registered from next-state index and digits so they always move together.
    always_comb begin
        pre_d = pre_q + 16'd1;
        idx_d = idx_q;
        if (pre_q == 16'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        an_d  = NUM_DIGITS'(1) << idx_d;
        seg_d = seg_of(idx_d, dig_d, dsign_d);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            val_q   <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            dsign_q <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            an_q    <= NUM_DIGITS'(1);
            seg_q   <= 7'h3F;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            dsign_q <= dsign_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == LATCH);
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// Self-checking bench for calc_display_driver: vector table, random loads vs. decimal model, corner sequences.
module tb_calc_display_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] value_in;
    logic        load;
    logic        busy, done;
    logic [6:0]  seg;
    logic [5:0]  an;

    int n_cmp = 0;
    int n_bad = 0;

    calc_display_driver #(.SCAN_DIV(SD), .NUM_DIGITS(6)) dut (
        .clk(clk), .RST(RST), .value_in(value_in), .load(load),
        .busy(busy), .done(done), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] PAT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct packed {
        logic [15:0]     v;
        logic [5:0][6:0] s;   // s[i] = expected seg at scan index i
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by division, display rules applied directly.
    function automatic logic [5:0][6:0] model(input logic [15:0] v);
        logic [5:0][6:0] r;
        int m, p;
        bit neg;
        m   = int'($signed(v));
        neg = (m < 0);
        if (neg) m = -m;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[i] = PAT[(m / p) % 10];
`ifdef DISP_LZB_EN
            if (i > 0 && m < p) r[i] = 7'h00;
`endif
            p = p * 10;
        end
        r[5] = neg ? 7'h40 : 7'h00;
        return r;
    endfunction

    task automatic load_and_check(input logic [15:0] v);
        @(negedge clk); value_in = v; load = 1'b1;
        @(negedge clk); load = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            chk($sformatf("busy c%0d", k), 32'(busy), 32'd1);
            chk($sformatf("done c%0d", k), 32'(done), 32'(k == 18));
            @(negedge clk);
        end
        chk("busy after", 32'(busy), 32'd0);
        chk("done after", 32'(done), 32'd0);
    endtask

    task automatic check_display(input string name, input logic [5:0][6:0] s);
        int idx;
        for (int c = 0; c < 6 * SD + 2; c++) begin
            chk({name, " an onehot"}, 32'($onehot(an)), 32'd1);
            idx = 0;
            for (int i = 0; i < 6; i++) if (an[i]) idx = i;
            chk($sformatf("%s seg[%0d]", name, idx), 32'(seg), 32'(s[idx]));
            @(negedge clk);
        end
    endtask

    vec_t tbl [6];

    initial begin
        int ndone, cnt;
        logic [5:0] prev;
        logic [15:0] rv;

        tbl[0] = '{16'd12345, {7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D}};
        tbl[1] = '{16'h8000,  {7'h40, 7'h4F, 7'h5B, 7'h07, 7'h7D, 7'h7F}};
        tbl[2] = '{16'd32767, {7'h00, 7'h4F, 7'h5B, 7'h07, 7'h7D, 7'h07}};
`ifdef DISP_LZB_EN
        tbl[3] = '{16'hFFFF,  {7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h06}};
        tbl[4] = '{16'd42,    {7'h00, 7'h00, 7'h00, 7'h00, 7'h66, 7'h5B}};
        tbl[5] = '{16'd0,     {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}};
`else
        tbl[3] = '{16'hFFFF,  {7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h06}};
        tbl[4] = '{16'd42,    {7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h66, 7'h5B}};
        tbl[5] = '{16'd0,     {7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
`endif

        RST = 1'b1; load = 1'b0; value_in = '0;
        repeat (3) @(negedge clk);
        chk("rst an", 32'(an), 32'h01);
        chk("rst seg", 32'(seg), 32'h3F);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        RST = 1'b0;
        check_display("rst disp", model(16'd0));

        for (int t = 0; t < 6; t++) begin
            load_and_check(tbl[t].v);
            check_display($sformatf("vec%0d", t), tbl[t].s);
        end

        for (int t = 0; t < 12; t++) begin
            rv = 16'($urandom);
            load_and_check(rv);
            check_display($sformatf("rnd %h", rv), model(rv));
        end

        // Load ignored while busy: one done, first value shown, then second load works.
        @(negedge clk); value_in = 16'd5; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk); value_in = 16'd7; load = 1'b1;
        @(negedge clk); load = 1'b0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("busy-load done count", 32'(ndone), 32'd1);
        check_display("busy-load disp5", model(16'd5));
        load_and_check(16'd7);
        check_display("disp7", model(16'd7));

        // Scan cadence and wrap.
        prev = an; cnt = 0;
        while (an == prev && cnt < 20) begin @(negedge clk); cnt++; end
        chk("scan sync timeout", 32'(cnt < 20), 32'd1);
        for (int k = 0; k < 8; k++) begin
            prev = an; cnt = 0;
            do begin @(negedge clk); cnt++; end while (an == prev && cnt < 20);
            chk("scan period", 32'(cnt), SD);
            chk("scan next an", 32'(an), 32'({prev[4:0], prev[5]}));
        end

        // Asynchronous reset mid-conversion: immediate reset state, no done, digits cleared.
        @(negedge clk); value_in = 16'd12345; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (5) @(negedge clk);
        #2 RST = 1'b1;
        #1;
        chk("async rst an", 32'(an), 32'h01);
        chk("async rst seg", 32'(seg), 32'h3F);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        @(negedge clk); RST = 1'b0;
        for (int c = 1; c <= SD; c++) begin
            @(negedge clk);
            chk($sformatf("scan restart c%0d", c), 32'(an), (c < SD) ? 32'h01 : 32'h02);
        end
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort no done", 32'(ndone), 32'd0);
        check_display("abort disp", model(16'd0));

        // Reset and load together: reset wins.
        @(negedge clk); value_in = 16'd5; load = 1'b1; RST = 1'b1;
        @(negedge clk); load = 1'b0; RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rst+load busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
